// File: rtl/cam_pattern_gen.sv
// Camera-sensor emulator: drives a parallel pixel bus with deterministic test frames from a divided clk.
// Build option: define CAM_PATTERN_GEN_LFSR_EN to make mode 3 an 8-bit LFSR instead of column index.
module cam_pattern_gen #(
    parameter int COLS   = 16,
    parameter int ROWS   = 12,
    parameter int DIV    = 2,
    parameter int FPORCH = 2,
    parameter int HBLANK = 4,
    parameter int VBLANK = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  solid_val,
    output logic        pixel_clk,
    output logic [7:0]  pixel_dat,
    output logic        frame_vld,
    output logic        line_vld,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FPORCH = 3'd1;
    localparam logic [2:0] S_ACTIVE = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_VBLANK = 3'd4;

    logic [DIV_W-1:0] div_q, div_d;
    logic             pclk_q, pclk_d;
    logic             div_wrap;
    logic             pix_tick;

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] row_q, row_d;
    logic [15:0] col_q, col_d;
    logic        fp_entry;
    logic        frame_end;
    logic        active_d;
    logic        fvld_d;

    logic [1:0]  mode_q;
    logic [7:0]  solid_q;
    logic [7:0]  pix_idx_q;
    logic [7:0]  pat;

    logic [7:0]  pixel_dat_q;
    logic        frame_vld_q;
    logic        line_vld_q;
    logic        frame_done_q;
    logic [15:0] frame_cnt_q;

    // Divider free-runs from reset; a pixel tick is the clk edge where pixel_clk falls.
    always_comb begin
        div_wrap = (div_q == DIV_LAST);
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        pclk_d   = div_wrap ? ~pclk_q : pclk_q;
    end

    assign pix_tick = div_wrap & pclk_q;

    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_FPORCH;
                    cnt_d   = '0;
                end
            end
            S_FPORCH: begin
                if (cnt_q == 16'(FPORCH - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ACTIVE: begin
                if (col_q == 16'(COLS - 1)) begin
                    state_d = (row_q == 16'(ROWS - 1)) ? S_VBLANK : S_HBLANK;
                    cnt_d   = '0;
                end else begin
                    col_d = col_q + 16'd1;
                end
            end
            S_HBLANK: begin
                if (cnt_q == 16'(HBLANK - 1)) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    row_d   = row_q + 16'd1;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_VBLANK: begin
                if (cnt_q == 16'(VBLANK - 1)) begin
                    state_d = enable ? S_FPORCH : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fp_entry  = (state_d == S_FPORCH) && (state_q != S_FPORCH);
        frame_end = (state_q == S_ACTIVE) && (state_d == S_VBLANK);
        active_d  = (state_d == S_ACTIVE);
        fvld_d    = (state_d == S_FPORCH) || (state_d == S_ACTIVE) || (state_d == S_HBLANK);
    end

`ifdef CAM_PATTERN_GEN_LFSR_EN
    logic [7:0] lfsr_q;

    // Fibonacci x^8+x^6+x^5+x^4+1: the current value is shown, then it steps for the next pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 8'hFF;
        end else if (pix_tick) begin
            if (fp_entry) begin
                lfsr_q <= 8'hFF;
            end else if (active_d) begin
                lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end
        end
    end
`endif

    // Pattern is evaluated for the pixel about to be presented, i.e. at (row_d, col_d).
    always_comb begin
        pat = 8'h00;
        case (mode_q)
            2'd0: pat = pix_idx_q;
            2'd1: pat = solid_q;
            2'd2: pat = (row_d[0] ^ col_d[0]) ? 8'hFF : 8'h00;
            2'd3: begin
`ifdef CAM_PATTERN_GEN_LFSR_EN
                pat = lfsr_q;
`else
                pat = col_d[7:0];
`endif
            end
            default: pat = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments; the later frame_done_q write wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            pclk_q       <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            mode_q       <= '0;
            solid_q      <= '0;
            pix_idx_q    <= '0;
            pixel_dat_q  <= '0;
            frame_vld_q  <= 1'b0;
            line_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            div_q        <= div_d;
            pclk_q       <= pclk_d;
            frame_done_q <= 1'b0;
            if (pix_tick) begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                row_q       <= row_d;
                col_q       <= col_d;
                frame_vld_q <= fvld_d;
                line_vld_q  <= active_d;
                pixel_dat_q <= active_d ? pat : 8'h00;
                if (frame_end) begin
                    frame_done_q <= 1'b1;
                    frame_cnt_q  <= frame_cnt_q + 16'd1;
                end
                if (fp_entry) begin
                    mode_q    <= mode;
                    solid_q   <= solid_val;
                    pix_idx_q <= '0;
                end else if (active_d) begin
                    pix_idx_q <= pix_idx_q + 8'd1;
                end
            end
        end
    end

    assign pixel_clk  = pclk_q;
    assign pixel_dat  = pixel_dat_q;
    assign frame_vld  = frame_vld_q;
    assign line_vld   = line_vld_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule
